// File: rtl/uart_tx_fifo_ctrl_if.sv
// Host write channel and transmitter hand-off signals of the UART TX buffer.
// The master side drives host data and the transmitter's tx_done; the slave side is the buffer.
interface uart_tx_fifo_ctrl_if #(
    parameter int D_W    = 8,
    parameter int ADDR_W = 4
);
    logic [D_W-1:0]  wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [D_W-1:0]  input_data;
    logic            tx_start;
    logic            tx_done;
    logic [ADDR_W:0] fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            busy;

    modport master (
        output wr_data, wr_valid, tx_done,
        input  wr_ready, input_data, tx_start, fifo_count, fifo_empty, fifo_full, busy
    );

    modport slave (
        input  wr_data, wr_valid, tx_done,
        output wr_ready, input_data, tx_start, fifo_count, fifo_empty, fifo_full, busy
    );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// DEPTH-entry TX byte FIFO feeding a UART transmitter: pop-to-tx_start is one cycle, write-to-tx_start two.
// Host is backpressured with wr_ready = ~fifo_full; the transmitter paces pops via tx_done.
module uart_tx_fifo_ctrl #(
    parameter int D_W    = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_fifo_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [D_W-1:0]    mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [D_W-1:0]    data_q, data_d;
    logic              empty, full, wr_en, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign wr_en = bus.wr_valid & ~full;
    // Pop only from IDLE and only on registered count, so a byte written this edge is never fallen through.
    assign pop   = (state_q == IDLE) & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        data_d     = data_q;
        rd_ptr_d   = rd_ptr_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d     = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    tx_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            data_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            data_q     <= data_d;
        end
    end

    assign bus.wr_ready   = ~full;
    assign bus.input_data = data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.fifo_count = count_q;
    assign bus.fifo_empty = empty;
    assign bus.fifo_full  = full;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scenario tasks plus a randomized run checked against a queue-based model of the TX buffer.
module tb_uart_tx_fifo_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    uart_tx_fifo_ctrl_if #(.D_W(8), .ADDR_W(4)) bus ();

    uart_tx_fifo_ctrl #(.D_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before looking at outputs or changing inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if ({bus.tx_start, bus.busy, bus.fifo_empty, bus.fifo_full, bus.wr_ready, bus.fifo_count, bus.input_data}
            !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_state: start/busy/empty/full/rdy/cnt/data got %b %b %b %b %b %0d %h, expected 0 0 1 0 1 0 00",
                     bus.tx_start, bus.busy, bus.fifo_empty, bus.fifo_full, bus.wr_ready, bus.fifo_count, bus.input_data);
        end
    endtask

    task automatic test_single_byte();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hA5;
        tick();
        bus.wr_valid = 1'b0;
        vectors++;
        if (bus.fifo_count !== 5'd1 || bus.tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after_write: count %0d start %b, expected 1 0", bus.fifo_count, bus.tx_start);
        end
        tick();
        vectors++;
        if (bus.tx_start !== 1'b1 || bus.input_data !== 8'hA5 || bus.busy !== 1'b1 || bus.fifo_count !== 5'd0) begin
            miscompares++;
            $display("FAIL single_start: start %b data %h busy %b count %0d, expected 1 a5 1 0",
                     bus.tx_start, bus.input_data, bus.busy, bus.fifo_count);
        end
        tick();
        vectors++;
        if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1 || bus.input_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_pulse_width: start %b busy %b data %h, expected 0 1 a5",
                     bus.tx_start, bus.busy, bus.input_data);
        end
        repeat (8) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.fifo_count !== 5'd0 || bus.tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: busy %b count %0d start %b, expected 0 0 0", bus.busy, bus.fifo_count, bus.tx_start);
        end
    endtask

    task automatic test_fill_and_full_pop();
        bus.tx_done = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(i);
            vectors++;
            if (bus.wr_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready: byte %0d wr_ready %b, expected 1", i, bus.wr_ready);
            end
            tick();
        end
        bus.wr_data = 8'h11;
        repeat (3) tick();
        vectors++;
        if (bus.fifo_count !== 5'd16 || bus.fifo_full !== 1'b1 || bus.wr_ready !== 1'b0 ||
            bus.input_data !== 8'h00 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full: count %0d full %b rdy %b data %h busy %b, expected 16 1 0 00 1",
                     bus.fifo_count, bus.fifo_full, bus.wr_ready, bus.input_data, bus.busy);
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        vectors++;
        if (bus.fifo_count !== 5'd16 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done: count %0d busy %b rdy %b, expected 16 0 0", bus.fifo_count, bus.busy, bus.wr_ready);
        end
        tick();
        vectors++;
        if (bus.fifo_count !== 5'd15 || bus.tx_start !== 1'b1 || bus.input_data !== 8'h01 || bus.wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_pop: count %0d start %b data %h rdy %b, expected 15 1 01 1",
                     bus.fifo_count, bus.tx_start, bus.input_data, bus.wr_ready);
        end
        tick();
        bus.wr_valid = 1'b0;
        vectors++;
        if (bus.fifo_count !== 5'd16) begin
            miscompares++;
            $display("FAIL full_refill: count %0d, expected 16", bus.fifo_count);
        end
        for (int b = 2; b <= 17; b++) begin
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
            for (int t = 0; t < 10 && bus.tx_start !== 1'b1; t++) tick();
            vectors++;
            if (bus.tx_start !== 1'b1 || bus.input_data !== 8'(b)) begin
                miscompares++;
                $display("FAIL drain_order: start %b data %h, expected 1 %h", bus.tx_start, bus.input_data, 8'(b));
            end
            tick();
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        vectors++;
        if (bus.fifo_count !== 5'd0 || bus.busy !== 1'b0 || bus.fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_end: count %0d busy %b empty %b, expected 0 0 1", bus.fifo_count, bus.busy, bus.fifo_empty);
        end
    endtask

    task automatic test_ordering();
        logic [7:0] frames [3];
        frames[0] = 8'h11;
        frames[1] = 8'h22;
        frames[2] = 8'h33;
        bus.wr_valid = 1'b1;
        bus.wr_data  = frames[0];
        tick();
        bus.wr_data  = frames[1];
        tick();
        vectors++;
        if (bus.tx_start !== 1'b1 || bus.input_data !== frames[0]) begin
            miscompares++;
            $display("FAIL order_first: start %b data %h, expected 1 11", bus.tx_start, bus.input_data);
        end
        bus.wr_data = frames[2];
        tick();
        bus.wr_valid = 1'b0;
        for (int f = 1; f < 3; f++) begin
            repeat (4) tick();
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
            vectors++;
            if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL order_gap: frame %0d start %b busy %b, expected 0 0", f, bus.tx_start, bus.busy);
            end
            tick();
            vectors++;
            if (bus.tx_start !== 1'b1 || bus.input_data !== frames[f]) begin
                miscompares++;
                $display("FAIL order_next: frame %0d start %b data %h, expected 1 %h", f, bus.tx_start, bus.input_data, frames[f]);
            end
        end
        repeat (4) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
        vectors++;
        if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0 || bus.fifo_count !== 5'd0) begin
            miscompares++;
            $display("FAIL order_end: start %b busy %b count %0d, expected 0 0 0", bus.tx_start, bus.busy, bus.fifo_count);
        end
    endtask

    task automatic test_spurious_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0 || bus.fifo_count !== 5'd0) begin
            miscompares++;
            $display("FAIL spurious_idle: busy %b start %b count %0d, expected 0 0 0", bus.busy, bus.tx_start, bus.fifo_count);
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h5A;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0 || bus.input_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL spurious_start: busy %b start %b data %h, expected 1 0 5a", bus.busy, bus.tx_start, bus.input_data);
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_release: busy %b, expected 0", bus.busy);
        end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] cur;
        int  cd;
        bit  in_frame, started, exp_start, chk_gap;
        cur = 8'h00;
        cd = 0;
        in_frame = 0;
        exp_start = 0;
        chk_gap = 0;
        for (int c = 0; c < 900; c++) begin
            started = 0;
            if (exp_start) begin
                vectors++;
                if (bus.tx_start !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rnd_gap_start: cycle %0d start %b, expected 1", c, bus.tx_start);
                end
            end
            if (bus.tx_start === 1'b1) begin
                vectors++;
                if (in_frame || q.size() == 0 || bus.input_data !== q[0]) begin
                    miscompares++;
                    $display("FAIL rnd_data: cycle %0d data %h, expected %h (queued %0d, in_frame %0d)",
                             c, bus.input_data, (q.size() > 0) ? q[0] : 8'h00, q.size(), in_frame);
                end
                if (q.size() > 0) cur = q.pop_front();
                in_frame = 1;
                started  = 1;
                cd       = $urandom_range(1, 12);
            end else if (in_frame) begin
                vectors++;
                if (bus.input_data !== cur) begin
                    miscompares++;
                    $display("FAIL rnd_hold: cycle %0d data %h, expected %h", c, bus.input_data, cur);
                end
            end
            exp_start = 0;
            if (chk_gap) begin
                vectors++;
                if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_gap_idle: cycle %0d start %b busy %b, expected 0 0", c, bus.tx_start, bus.busy);
                end
                exp_start = (q.size() > 0);
                chk_gap   = 0;
            end
            vectors++;
            if (bus.fifo_count !== 5'(q.size()) || bus.fifo_full !== (q.size() == 16) ||
                bus.wr_ready !== (q.size() != 16) || bus.fifo_empty !== (q.size() == 0)) begin
                miscompares++;
                $display("FAIL rnd_count: cycle %0d count %0d full %b rdy %b empty %b, expected count %0d",
                         c, bus.fifo_count, bus.fifo_full, bus.wr_ready, bus.fifo_empty, q.size());
            end
            bus.tx_done = 1'b0;
            if (in_frame && !started) begin
                cd--;
                if (cd == 0) begin
                    bus.tx_done = 1'b1;
                    in_frame    = 0;
                    chk_gap     = 1;
                end
            end
            if (c < 500 && $urandom_range(0, 2) != 0) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = 8'($urandom);
                if (bus.wr_ready === 1'b1) q.push_back(bus.wr_data);
            end else begin
                bus.wr_valid = 1'b0;
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.tx_done  = 1'b0;
        vectors++;
        if (q.size() != 0 || in_frame || bus.busy !== 1'b0 || bus.fifo_count !== 5'd0) begin
            miscompares++;
            $display("FAIL rnd_drain: queued %0d in_frame %0d busy %b count %0d, expected all idle",
                     q.size(), in_frame, bus.busy, bus.fifo_count);
        end
    endtask

    task automatic test_reset_midframe();
        bus.wr_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.wr_data = 8'(8'h30 + i);
            tick();
        end
        bus.wr_valid = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0 || bus.fifo_count !== 5'd4) begin
            miscompares++;
            $display("FAIL midframe_setup: busy %b start %b count %0d, expected 1 0 4", bus.busy, bus.tx_start, bus.fifo_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({bus.tx_start, bus.input_data, bus.fifo_count, bus.busy, bus.wr_ready, bus.fifo_empty}
            !== {1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL midframe_reset: start %b data %h count %0d busy %b rdy %b empty %b, expected 0 00 0 0 1 1",
                     bus.tx_start, bus.input_data, bus.fifo_count, bus.busy, bus.wr_ready, bus.fifo_empty);
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
        vectors++;
        if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0 || bus.fifo_count !== 5'd0) begin
            miscompares++;
            $display("FAIL midframe_after: start %b busy %b count %0d, expected 0 0 0", bus.tx_start, bus.busy, bus.fifo_count);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.tx_done  = 1'b0;
        test_reset();
        test_single_byte();
        test_fill_and_full_pop();
        test_ordering();
        test_spurious_done();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
